// File: rtl/sensor_seq_gen.sv
// Drives the a/b optical-sensor lines through an entering or leaving car pattern on command.
// Each of the four phases is held for HOLD_CYCLES clocks; done pulses once per completed sequence.
module sensor_seq_gen #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic start_in,
   input  logic start_out,
   output logic a,
   output logic b,
   output logic busy,
   output logic done,
   output logic dir
);

   typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_d, b_d, busy_d, done_d, dir_d;

   // State, hold counter and all outputs are registered together
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a       <= 1'b0;
         b       <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dir     <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a       <= a_d;
         b       <= b_d;
         busy    <= busy_d;
         done    <= done_d;
         dir     <= dir_d;
      end
   end

   // Next state plus next output values, derived from the upcoming state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir;
      done_d  = 1'b0;
      a_d     = 1'b0;
      b_d     = 1'b0;

      case (state_q)
         IDLE: begin
            // Simultaneous requests are contradictory and are dropped
            if (start_in ^ start_out) begin
               state_d = PH1;
               cnt_d   = '0;
               dir_d   = start_in;
            end
         end
         default: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               case (state_q)
                  PH1:     state_d = PH2;
                  PH2:     state_d = PH3;
                  PH3:     state_d = GAP;
                  GAP: begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
                  default: state_d = IDLE;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase

      busy_d = (state_d != IDLE);

      // Leaving is the entering pattern mirrored, so only one line toggles per phase
      case (state_d)
         PH1:     {a_d, b_d} = dir_d ? 2'b10 : 2'b01;
         PH2:     {a_d, b_d} = 2'b11;
         PH3:     {a_d, b_d} = dir_d ? 2'b01 : 2'b10;
         default: {a_d, b_d} = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_sensor_seq_gen.sv
// Bench for sensor_seq_gen: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance share stimulus and are
// compared every cycle against a position-in-sequence reference model.
module tb_sensor_seq_gen;

   localparam int H0 = 4;
   localparam int H1 = 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start_in = 1'b0;
   logic start_out = 1'b0;

   logic a0, b0, busy0, done0, dir0;
   logic a1, b1, busy1, done1, dir1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sensor_seq_gen #(.HOLD_CYCLES(H0), .CNT_W(8)) dut0 (
      .clk(clk), .reset(reset), .start_in(start_in), .start_out(start_out),
      .a(a0), .b(b0), .busy(busy0), .done(done0), .dir(dir0)
   );

   sensor_seq_gen #(.HOLD_CYCLES(H1), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .start_in(start_in), .start_out(start_out),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .dir(dir1)
   );

   logic [4:0] obs0, obs1, exp0, exp1;
   assign obs0 = {a0, b0, busy0, done0, dir0};
   assign obs1 = {a1, b1, busy1, done1, dir1};

   // Reference: pos = cycles since the start was accepted, -1 when idle
   int pos0, pos1;
   bit mdir0, mdir1;

   function automatic logic [4:0] expect_of(input int pos, input int h, input bit d);
      int phase;
      logic [1:0] ab;
      if (pos < 0) return {4'b0000, d};
      if (pos == 4 * h) return {4'b0001, d};
      phase = pos / h;
      case (phase)
         0:       ab = d ? 2'b10 : 2'b01;
         1:       ab = 2'b11;
         2:       ab = d ? 2'b01 : 2'b10;
         default: ab = 2'b00;
      endcase
      return {ab, 2'b10, d};
   endfunction

   assign exp0 = expect_of(pos0, H0, mdir0);
   assign exp1 = expect_of(pos1, H1, mdir1);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos0 = -1; mdir0 = 1'b1;
         pos1 = -1; mdir1 = 1'b1;
      end else begin
         if (pos0 < 0 || pos0 == 4 * H0) begin
            if (start_in != start_out) begin pos0 = 0; mdir0 = start_in; end
            else pos0 = -1;
         end else pos0++;
         if (pos1 < 0 || pos1 == 4 * H1) begin
            if (start_in != start_out) begin pos1 = 0; mdir1 = start_in; end
            else pos1 = -1;
         end else pos1++;
      end
   end

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs0 !== 5'b00001) begin errors++; $display("FAIL reset_hold0 got %b want 00001", obs0); end
         checks++;
         if (obs1 !== 5'b00001) begin errors++; $display("FAIL reset_hold1 got %b want 00001", obs1); end
      end
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (obs0 !== 5'b00001) begin errors++; $display("FAIL idle0 cyc %0d got %b want 00001", i, obs0); end
      end
   endtask

   task automatic test_enter();
      int busy_cnt = 0, done_cnt = 0;
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      busy_cnt += busy0;
      for (int i = 0; i < 22; i++) begin
         checks++;
         if (obs0 !== exp0) begin errors++; $display("FAIL enter0 cyc %0d got %b want %b", i, obs0, exp0); end
         checks++;
         if (obs1 !== exp1) begin errors++; $display("FAIL enter1 cyc %0d got %b want %b", i, obs1, exp1); end
         if (done0) begin
            checks++;
            if (dir0 !== 1'b1) begin errors++; $display("FAIL enter_dir got %b want 1", dir0); end
         end
         done_cnt += done0;
         @(negedge clk);
         busy_cnt += busy0;
      end
      checks++;
      if (busy_cnt != 4 * H0) begin errors++; $display("FAIL enter_busy_len got %0d want %0d", busy_cnt, 4 * H0); end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL enter_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_leave();
      int done_cnt = 0;
      logic [1:0] first_ab;
      start_out = 1'b1;
      @(negedge clk);
      start_out = 1'b0;
      first_ab = {a0, b0};
      checks++;
      if (first_ab !== 2'b01) begin errors++; $display("FAIL leave_first_ab got %b want 01", first_ab); end
      for (int i = 0; i < 22; i++) begin
         checks++;
         if (obs0 !== exp0) begin errors++; $display("FAIL leave0 cyc %0d got %b want %b", i, obs0, exp0); end
         checks++;
         if (obs1 !== exp1) begin errors++; $display("FAIL leave1 cyc %0d got %b want %b", i, obs1, exp1); end
         done_cnt += done0;
         @(negedge clk);
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL leave_done_cnt got %0d want 1", done_cnt); end
      checks++;
      if (dir0 !== 1'b0) begin errors++; $display("FAIL leave_dir got %b want 0", dir0); end
   endtask

   task automatic test_ignore();
      int busy_cnt = 0;
      start_in = 1'b1; start_out = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs0 !== 5'b00000) begin errors++; $display("FAIL both_start0 got %b want 00000", obs0); end
         checks++;
         if (obs1 !== exp1) begin errors++; $display("FAIL both_start1 got %b want %b", obs1, exp1); end
      end
      start_out = 1'b0;
      @(negedge clk);
      start_in = 1'b0;
      busy_cnt += busy0;
      for (int i = 0; i < 24; i++) begin
         // Re-request while dut0 sits in its second phase
         start_in = (i == 5 || i == 6);
         checks++;
         if (obs0 !== exp0) begin errors++; $display("FAIL ignore0 cyc %0d got %b want %b", i, obs0, exp0); end
         checks++;
         if (obs1 !== exp1) begin errors++; $display("FAIL ignore1 cyc %0d got %b want %b", i, obs1, exp1); end
         @(negedge clk);
         busy_cnt += busy0;
      end
      start_in = 1'b0;
      checks++;
      if (busy_cnt != 4 * H0) begin errors++; $display("FAIL ignore_busy_len got %0d want %0d", busy_cnt, 4 * H0); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int done_cnt = 0;
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({a0, b0} !== 2'b11) begin errors++; $display("FAIL mid_in_ph2 got %b want 11", {a0, b0}); end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs0 !== 5'b00001) begin errors++; $display("FAIL mid_async0 got %b want 00001", obs0); end
      checks++;
      if (obs0 !== exp0) begin errors++; $display("FAIL mid_model0 got %b want %b", obs0, exp0); end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (obs0 !== exp0) begin errors++; $display("FAIL mid_after0 cyc %0d got %b want %b", i, obs0, exp0); end
         done_cnt += done0;
      end
      checks++;
      if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int done_cnt = 0;
      start_in = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         checks++;
         if (obs1 !== exp1) begin errors++; $display("FAIL b2b1 cyc %0d got %b want %b", i, obs1, exp1); end
         checks++;
         if (obs0 !== exp0) begin errors++; $display("FAIL b2b0 cyc %0d got %b want %b", i, obs0, exp0); end
         done_cnt += done1;
      end
      start_in = 1'b0;
      checks++;
      if (done_cnt != 3) begin errors++; $display("FAIL b2b_done_cnt got %0d want 3", done_cnt); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         start_in  = ($urandom_range(0, 5) == 0);
         start_out = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         checks++;
         if (obs0 !== exp0) begin errors++; $display("FAIL rand0 cyc %0d got %b want %b", i, obs0, exp0); end
         checks++;
         if (obs1 !== exp1) begin errors++; $display("FAIL rand1 cyc %0d got %b want %b", i, obs1, exp1); end
      end
      start_in = 1'b0; start_out = 1'b0;
   endtask

   initial begin
      test_reset();
      test_enter();
      test_leave();
      test_ignore();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sensor_seq_gen.md
Name: sensor_seq_gen

Overview:
- Sensor-sequence generator for the parking-lot barrier: the transmitter-side counterpart of the sequence detector.
- On command, it drives the two optical-sensor lines a,b through the exact pattern a car produces when entering or leaving.
- Used to exercise the estacionamiento detector/counter chain on the board and in simulation without physical sensors.
- Outputs are registered and connect directly to the detector's a,b inputs.

Parameters:
- HOLD_CYCLES, 4, clock cycles each sensor phase is held; legal range 1..255.
- CNT_W, 8, width of the internal phase-hold counter; must hold HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_in  input  1  request an "entering car" sequence; sampled only in IDLE.
- start_out  input  1  request a "leaving car" sequence; sampled only in IDLE.
- a  output  1  sensor A line (outer sensor), registered.
- b  output  1  sensor B line (inner sensor), registered.
- busy  output  1  high while a sequence is being generated.
- done  output  1  one-cycle pulse when a sequence completes.
- dir  output  1  direction of the current or last sequence: 1 = entering, 0 = leaving; registered.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, a=0, b=0, busy=0, done=0, dir=1, hold counter=0.
- States: IDLE, PH1, PH2, PH3, GAP.
- Sensor pattern per state, given as (a,b):
  - Entering: PH1=(1,0), PH2=(1,1), PH3=(0,1), GAP=(0,0).
  - Leaving: PH1=(0,1), PH2=(1,1), PH3=(1,0), GAP=(0,0).
- IDLE outputs (0,0), busy=0.
- Start (IDLE only), at rising edge k:
  - start_in=1, start_out=0 → dir<=1, state<=PH1, busy<=1, counter<=0.
  - start_out=1, start_in=0 → dir<=0, state<=PH1, busy<=1, counter<=0.
  - Both 1 → both ignored, stay IDLE, no output change.
- start_in and start_out are ignored in every state other than IDLE; no queuing.
- Phase timing:
  - Each of PH1, PH2, PH3 and GAP lasts exactly HOLD_CYCLES cycles.
  - The counter increments each cycle. When it equals HOLD_CYCLES-1, it clears and the state advances PH1→PH2→PH3→GAP→IDLE.
- a/b change on the same edge as the state. The pattern is visible from edge k+1 (first edge after the start request is registered at edge k). Only one of a,b toggles per transition, so no glitch patterns are generated.
- Completion:
  - On the GAP→IDLE edge (edge k+4*HOLD_CYCLES), busy<=0 and done<=1 for exactly one cycle.
  - a,b are already (0,0) at this point.
- A new start may be accepted in the same cycle done is high, because the state is IDLE. The next sequence then starts back-to-back, and done still pulses only once per sequence.
- dir holds its value until the next accepted start.
- Reset mid-sequence: immediate return to reset values. done is not pulsed, and the partial pattern is abandoned. The downstream detector sees an aborted car and must not count it. Verify this at system level.
- HOLD_CYCLES=1 is legal: each phase lasts one cycle, and a full sequence takes 4 cycles.
- Counter width: CNT_W bits, unsigned, with no wrap in legal use.

Test Plan:
- Reset then idle, HOLD_CYCLES=4, no starts for 20 cycles → a=b=0, busy=0, done=0, dir=1 throughout.
- start_in pulse for 1 cycle at edge k → (a,b)=10 for 4 cycles, then 11×4, 01×4, 00×4. busy=1 from k through k+15. done=1 only in the cycle after edge k+16, with dir=1.
- start_out pulse → 01×4, 11×4, 10×4, 00×4. done after 16 cycles, dir=0. In the top-level bench, the counter goes 1→0 after a preceding entry.
- start_in and start_out asserted together in IDLE → no state change, a=b=0, busy=0. start_in asserted during PH2 → ignored, sequence length unchanged.
- reset pulled low during PH2 of an entry → a=b=0, busy=0 immediately and asynchronously. No done pulse. The downstream count is unchanged.
- HOLD_CYCLES=1, start_in held high continuously → back-to-back entries, each 4 cycles long with one done pulse per sequence. Three sequences yield count=3 in the top-level bench.
